// File: rtl/seq_gen.sv
// seq_gen: serial pattern generator.
// Shifts a latched PAT_W-bit pattern out MSB-first, one bit per clock,
// repeated `reps` times with `gap` idle cycles between repetitions.
// Optional build macro SEQ_GEN_LFSR_EN: gap cycles carry 16-bit LFSR noise
// on x (valid stays low) instead of a constant 0.
module seq_gen #(
    parameter int PAT_W = 6,
    parameter int REP_W = 8,
    parameter int GAP_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [PAT_W-1:0] pattern_in,
    input  logic [REP_W-1:0] reps,
    input  logic [GAP_W-1:0] gap,
    output logic             x,
    output logic             valid,
    output logic             busy,
    output logic             done,
    output logic [2:0]       state
);

    localparam int BW = (PAT_W > 1) ? $clog2(PAT_W) : 1;

    typedef enum logic [2:0] {
        IDLE  = 3'b000,
        SHIFT = 3'b001,
        GAP   = 3'b010,
        DONE  = 3'b011
    } state_t;

    state_t           state_reg;
    logic [PAT_W-1:0] pat_reg;   // latched pattern, used for reloads
    logic [PAT_W-1:0] sh_reg;    // bits still to be presented, MSB next
    logic [BW-1:0]    bcnt_reg;  // bits remaining after the one on x
    logic [REP_W-1:0] rcnt_reg;  // repetitions remaining, incl. current
    logic [GAP_W-1:0] gcnt_reg;  // gap cycles remaining, incl. current
    logic [GAP_W-1:0] gap_reg;   // latched gap length

    assign state = state_reg;

`ifdef SEQ_GEN_LFSR_EN
    logic [15:0] lfsr_reg;
    logic [15:0] lfsr_next;
    // Fibonacci LFSR, taps 16,14,13,11
    assign lfsr_next = {lfsr_reg[14:0], lfsr_reg[15] ^ lfsr_reg[13] ^ lfsr_reg[12] ^ lfsr_reg[10]};
`endif

    // Main FSM: all outputs are registered and set on the transition into a state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
            pat_reg   <= '0;
            sh_reg    <= '0;
            bcnt_reg  <= '0;
            rcnt_reg  <= '0;
            gcnt_reg  <= '0;
            gap_reg   <= '0;
            x         <= 1'b0;
            valid     <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
`ifdef SEQ_GEN_LFSR_EN
            lfsr_reg  <= 16'hACE1;
`endif
        end else begin
            done <= 1'b0;
            case (state_reg)
                IDLE: begin
                    x     <= 1'b0;
                    valid <= 1'b0;
                    busy  <= 1'b0;
                    if (start) begin
                        pat_reg <= pattern_in;
                        gap_reg <= gap;
                        rcnt_reg <= reps;
                        if (reps != '0) begin
                            sh_reg    <= pattern_in << 1;
                            bcnt_reg  <= BW'(PAT_W - 1);
                            x         <= pattern_in[PAT_W-1];
                            valid     <= 1'b1;
                            busy      <= 1'b1;
                            state_reg <= SHIFT;
                        end else begin
                            // nothing to send: straight to the completion pulse
                            done      <= 1'b1;
                            state_reg <= DONE;
                        end
                    end
                end

                SHIFT: begin
                    if (bcnt_reg != '0) begin
                        x        <= sh_reg[PAT_W-1];
                        sh_reg   <= sh_reg << 1;
                        bcnt_reg <= bcnt_reg - 1'b1;
                    end else begin
                        // LSB cycle ends here: one repetition complete
                        rcnt_reg <= rcnt_reg - 1'b1;
                        if (rcnt_reg == REP_W'(1)) begin
                            x         <= 1'b0;
                            valid     <= 1'b0;
                            busy      <= 1'b0;
                            done      <= 1'b1;
                            state_reg <= DONE;
                        end else if (gap_reg != '0) begin
                            valid     <= 1'b0;
                            gcnt_reg  <= gap_reg;
                            state_reg <= GAP;
`ifdef SEQ_GEN_LFSR_EN
                            x         <= lfsr_reg[0];
`else
                            x         <= 1'b0;
`endif
                        end else begin
                            // back-to-back: reload and present the MSB at once
                            sh_reg   <= pat_reg << 1;
                            bcnt_reg <= BW'(PAT_W - 1);
                            x        <= pat_reg[PAT_W-1];
                            valid    <= 1'b1;
                        end
                    end
                end

                GAP: begin
                    if (gcnt_reg == GAP_W'(1)) begin
                        sh_reg    <= pat_reg << 1;
                        bcnt_reg  <= BW'(PAT_W - 1);
                        x         <= pat_reg[PAT_W-1];
                        valid     <= 1'b1;
                        state_reg <= SHIFT;
                    end else begin
                        gcnt_reg <= gcnt_reg - 1'b1;
`ifdef SEQ_GEN_LFSR_EN
                        lfsr_reg <= lfsr_next;
                        x        <= lfsr_next[0];
`else
                        x        <= 1'b0;
`endif
                    end
                end

                DONE: begin
                    x         <= 1'b0;
                    valid     <= 1'b0;
                    busy      <= 1'b0;
                    state_reg <= IDLE;
                end

                default: begin
                    x         <= 1'b0;
                    valid     <= 1'b0;
                    busy      <= 1'b0;
                    state_reg <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_gen.sv
// tb_seq_gen: table-driven check of seq_gen (default build, gap x=0),
// plus hand-written reset and start-while-busy sequences.
module tb_seq_gen;

    localparam int PAT_W = 6;
    localparam int REP_W = 8;
    localparam int GAP_W = 4;

    logic             clk;
    logic             rst;
    logic             start;
    logic [PAT_W-1:0] pattern_in;
    logic [REP_W-1:0] reps;
    logic [GAP_W-1:0] gap;
    logic             x;
    logic             valid;
    logic             busy;
    logic             done;
    logic [2:0]       state;

    int total;
    int bad;

    seq_gen #(.PAT_W(PAT_W), .REP_W(REP_W), .GAP_W(GAP_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .pattern_in (pattern_in),
        .reps       (reps),
        .gap        (gap),
        .x          (x),
        .valid      (valid),
        .busy       (busy),
        .done       (done),
        .state      (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [PAT_W-1:0] pat;
        logic [REP_W-1:0] nrep;
        logic [GAP_W-1:0] ngap;
        bit               repulse;   // pulse start with another pattern mid-transfer
        int               exp_busy;  // cycles with busy=1
        int               exp_valid; // cycles with valid=1
        int               exp_ones;  // valid cycles with x=1
        int               exp_done;  // cycle (after start edge) of the done pulse
        int               exp_match; // detector-style matches of pat in valid stream
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    // Start one transfer and tally its outputs cycle by cycle
    task automatic run_vec(input int idx, input vec_t v);
        int c, nb, nv, n1, dc, xerr, nm, ndone;
        logic [PAT_W-1:0] hist;
        string tag;
        nb = 0; nv = 0; n1 = 0; dc = 0; xerr = 0; nm = 0; ndone = 0;
        hist = '0;
        @(negedge clk);
        start = 1'b1; pattern_in = v.pat; reps = v.nrep; gap = v.ngap;
        @(negedge clk);
        start = 1'b0;
        for (c = 1; c <= 2000; c++) begin
            if (v.repulse && c == 3) begin
                start = 1'b1; pattern_in = 6'b010100; reps = 8'd9; gap = 4'd3;
            end else begin
                start = 1'b0;
            end
            if (busy) nb++;
            if (valid) begin
                if (x !== v.pat[PAT_W-1-(nv % PAT_W)]) xerr++;
                if (x) n1++;
                hist = {hist[PAT_W-2:0], x};
                nv++;
                if (nv >= PAT_W && hist == v.pat) nm++;
            end else if (x !== 1'b0) begin
                xerr++;
            end
            if (done) begin
                ndone++;
                dc = c;
                break;
            end
            @(negedge clk);
        end
        start = 1'b0;
        repeat (2) begin
            @(negedge clk);
            if (done) ndone++;
            if (busy || valid) xerr++;
        end
        tag = $sformatf("v%0d", idx);
        check({tag, "_busy"},  nb,    v.exp_busy);
        check({tag, "_valid"}, nv,    v.exp_valid);
        check({tag, "_ones"},  n1,    v.exp_ones);
        check({tag, "_done"},  dc,    v.exp_done);
        check({tag, "_xerr"},  xerr,  0);
        check({tag, "_match"}, nm,    v.exp_match);
        check({tag, "_npul"},  ndone, 1);
        check({tag, "_state"}, int'(state), 0);
        $display("vec %0d pat=%b reps=%0d gap=%0d busy=%0d valid=%0d ones=%0d done@%0d match=%0d",
                 idx, v.pat, v.nrep, v.ngap, nb, nv, n1, dc, nm);
    endtask

    initial begin
        total = 0; bad = 0;
        rst = 1'b1; start = 1'b0; pattern_in = '0; reps = '0; gap = '0;

        //        pat        reps  gap  rp  busy  valid ones done  match
        vecs[0] = '{6'b101011, 8'd1,   4'd0,  0, 6,    6,    4,   7,    1};
        vecs[1] = '{6'b101011, 8'd3,   4'd2,  0, 22,   18,   12,  23,   3};
        vecs[2] = '{6'b110000, 8'd2,   4'd0,  0, 12,   12,   4,   13,   2};
        vecs[3] = '{6'b101011, 8'd0,   4'd5,  0, 0,    0,    0,   1,    0};
        vecs[4] = '{6'b111111, 8'd2,   4'd15, 0, 27,   12,   12,  28,   7};
        vecs[5] = '{6'b101011, 8'd4,   4'd0,  0, 24,   24,   16,  25,   4};
        vecs[6] = '{6'b101011, 8'd1,   4'd0,  1, 6,    6,    4,   7,    1};
        vecs[7] = '{6'b100001, 8'd255, 4'd0,  0, 1530, 1530, 510, 1531, 255};

        // reset values
        repeat (2) @(negedge clk);
        check("rst_x",     int'(x),     0);
        check("rst_valid", int'(valid), 0);
        check("rst_busy",  int'(busy),  0);
        check("rst_done",  int'(done),  0);
        check("rst_state", int'(state), 0);
        rst = 1'b0;

        for (int i = 0; i < 8; i++) run_vec(i, vecs[i]);

        // reset mid-SHIFT after bit 3: immediate abort, no done afterwards
        begin
            int nd;
            nd = 0;
            @(negedge clk);
            start = 1'b1; pattern_in = 6'b101011; reps = 8'd1; gap = 4'd0;
            @(negedge clk);
            start = 1'b0;
            repeat (3) @(negedge clk);   // now in cycle with bit 4 (x=0)
            check("mid_valid_pre", int'(valid), 1);
            #1 rst = 1'b1;
            #1;
            check("abort_x",     int'(x),     0);
            check("abort_valid", int'(valid), 0);
            check("abort_busy",  int'(busy),  0);
            check("abort_state", int'(state), 0);
            @(negedge clk);
            rst = 1'b0;
            repeat (8) begin
                @(negedge clk);
                if (done || busy || valid) nd++;
            end
            check("abort_quiet", nd, 0);
            $display("reset abort sequence: activity after abort=%0d", nd);
        end

        // normal transfer after the abort
        run_vec(8, vecs[0]);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
